// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file write-back path: widths, requester
// slot assignments and the write-back request record.
package wb_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    // Fixed requester slots on the write-back arbiter.
    localparam int REQ_ALU = 0;
    localparam int REQ_LSU = 1;
    localparam int REQ_CSR = 2;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

endpackage : wb_pkg

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus: packed requester handshake on one side, the register file
// write port on the other. Requesters drive the master side.
interface regfile_wb_arbiter_if #(
    parameter int N_REQ      = 3,
    parameter int XLEN       = wb_pkg::XLEN,
    parameter int REG_ADDR_W = wb_pkg::REG_ADDR_W
);

    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ-1:0]            req_ready;
    logic [N_REQ*REG_ADDR_W-1:0] req_rd;
    logic [N_REQ*XLEN-1:0]       req_data;

    logic                        rf_wr_en;
    logic [REG_ADDR_W-1:0]       rf_write_select;
    logic [XLEN-1:0]             rf_data_in;

    modport master (
        output req_valid, req_rd, req_data,
        input  req_ready, rf_wr_en, rf_write_select, rf_data_in
    );

    modport slave (
        input  req_valid, req_rd, req_data,
        output req_ready, rf_wr_en, rf_write_select, rf_data_in
    );

endinterface : regfile_wb_arbiter_if

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searching from the pointer,
// pointer advances past the winner on every grant.
module rr_arbiter #(
    parameter int N     = 3,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W-1:0] ptr_reg;
    logic [IDX_W-1:0] ptr_next;
    logic [IDX_W-1:0] cand;
    logic             found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int k = 0; k < N; k++) begin
            cand = IDX_W'((int'(ptr_reg) + k) % N);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        ptr_next = ptr_reg;
        if (found) begin
            ptr_next = (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

endmodule : rr_arbiter

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file's single write port, with a
// registered output stage and a pending-write (RAW hazard) scoreboard.
module regfile_wb_arbiter #(
    parameter int N_REQ      = 3,
    parameter int XLEN       = wb_pkg::XLEN,
    parameter int REG_ADDR_W = wb_pkg::REG_ADDR_W
) (
    input  logic                      clock,
    input  logic                      reset_n,
    regfile_wb_arbiter_if.slave       wb,
    input  logic                      sb_set_valid,
    input  logic [REG_ADDR_W-1:0]     sb_set_rd,
    input  logic                      sb_flush,
    input  logic [REG_ADDR_W-1:0]     q_rs1,
    input  logic [REG_ADDR_W-1:0]     q_rs2,
    output logic                      q_rs1_busy,
    output logic                      q_rs2_busy,
    output logic [2**REG_ADDR_W-1:0]  busy
);

    localparam int NUM_REGS = 2**REG_ADDR_W;
    localparam int IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]      grant;
    logic [IDX_W-1:0]      grant_idx;
    logic                  handshake;

    logic [REG_ADDR_W-1:0] rd_a   [N_REQ];
    logic [XLEN-1:0]       data_a [N_REQ];
    logic [REG_ADDR_W-1:0] sel_rd;
    logic [XLEN-1:0]       sel_data;

    logic                  wr_en_reg,  wr_en_next;
    logic [REG_ADDR_W-1:0] sel_reg,    sel_next;
    logic [XLEN-1:0]       data_reg,   data_next;

    logic [NUM_REGS-1:0]   busy_vec;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign rd_a[gi]   = wb.req_rd[REG_ADDR_W*gi +: REG_ADDR_W];
            assign data_a[gi] = wb.req_data[XLEN*gi +: XLEN];
        end
    endgenerate

    rr_arbiter #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .clock     (clock),
        .reset_n   (reset_n),
        .req       (wb.req_valid),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign wb.req_ready = grant;
    assign handshake    = |grant;
    assign sel_rd       = rd_a[grant_idx];
    assign sel_data     = data_a[grant_idx];

    // An x0 write still completes the handshake but never reaches the port;
    // select/data only move when a real write is launched.
    always_comb begin
        wr_en_next = handshake && (sel_rd != '0);
        sel_next   = sel_reg;
        data_next  = data_reg;
        if (wr_en_next) begin
            sel_next  = sel_rd;
            data_next = sel_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_en_reg <= 1'b0;
            sel_reg   <= '0;
            data_reg  <= '0;
        end else begin
            wr_en_reg <= wr_en_next;
            sel_reg   <= sel_next;
            data_reg  <= data_next;
        end
    end

    assign wb.rf_wr_en        = wr_en_reg;
    assign wb.rf_write_select = sel_reg;
    assign wb.rf_data_in      = data_reg;

    // Scoreboard bit per register: set beats commit-clear and flush.
    assign busy_vec[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_sb
            logic bit_reg;
            logic clr_hit;
            logic set_hit;

            assign clr_hit = wr_en_reg && (sel_reg == REG_ADDR_W'(gi));
            assign set_hit = sb_set_valid && (sb_set_rd == REG_ADDR_W'(gi));

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    bit_reg <= 1'b0;
                end else begin
                    bit_reg <= set_hit | (bit_reg & ~clr_hit & ~sb_flush);
                end
            end

            assign busy_vec[gi] = bit_reg;
        end
    endgenerate

    assign busy       = busy_vec;
    assign q_rs1_busy = busy_vec[q_rs1];
    assign q_rs2_busy = busy_vec[q_rs2];

endmodule : regfile_wb_arbiter

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: expected writes are queued by the
// stimulus and compared by a negedge monitor on the register-file port.
module tb_regfile_wb_arbiter;
    import wb_pkg::*;

    localparam int N = 3;

    logic            clock = 1'b0;
    logic            reset_n = 1'b0;
    logic            sb_set_valid = 1'b0;
    logic [4:0]      sb_set_rd = '0;
    logic            sb_flush = 1'b0;
    logic [4:0]      q_rs1 = '0;
    logic [4:0]      q_rs2 = '0;
    logic            q_rs1_busy;
    logic            q_rs2_busy;
    logic [31:0]     busy;

    int n_checks = 0;
    int n_fail   = 0;

    wb_req_t         exp_q [$];
    wb_req_t         mon_e;
    logic [XLEN-1:0] rf_model [NUM_REGS];

    regfile_wb_arbiter_if #(.N_REQ(N), .XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) wb ();

    regfile_wb_arbiter #(
        .N_REQ      (N),
        .XLEN       (XLEN),
        .REG_ADDR_W (REG_ADDR_W)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .wb           (wb),
        .sb_set_valid (sb_set_valid),
        .sb_set_rd    (sb_set_rd),
        .sb_flush     (sb_flush),
        .q_rs1        (q_rs1),
        .q_rs2        (q_rs2),
        .q_rs1_busy   (q_rs1_busy),
        .q_rs2_busy   (q_rs2_busy),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            $display("ok   %s = %h", name, act);
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [4:0] rd, input logic [31:0] d);
        wb.req_valid[i]       = v;
        wb.req_rd[5*i +: 5]   = rd;
        wb.req_data[32*i +: 32] = d;
    endtask

    // Register file model: commits on the negedge while the port is enabled.
    always @(negedge clock) begin
        if (reset_n && wb.rf_wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {32'd0, 27'd0, wb.rf_write_select}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_select", {59'd0, wb.rf_write_select}, {59'd0, mon_e.rd});
                check("wr_data", {32'd0, wb.rf_data_in}, {32'd0, mon_e.data});
            end
            rf_model[wb.rf_write_select] = wb.rf_data_in;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "timeout");
    end

    initial begin
        for (int r = 0; r < NUM_REGS; r++) rf_model[r] = '0;
        wb.req_valid = '0;
        wb.req_rd    = '0;
        wb.req_data  = '0;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("reset_wr_en", {63'd0, wb.rf_wr_en}, 64'd0);
        check("reset_select", {59'd0, wb.rf_write_select}, 64'd0);
        check("reset_data", {32'd0, wb.rf_data_in}, 64'd0);
        check("reset_busy", {32'd0, busy}, 64'd0);
        @(negedge clock);
        #2 reset_n = 1'b1;
        cycle();

        // Single request from requester 0
        set_req(REQ_ALU, 1'b1, 5'd5, 32'hDEAD_BEEF);
        #1;
        check("single_ready", {61'd0, wb.req_ready}, 64'b001);
        exp_q.push_back('{rd: 5'd5, data: 32'hDEAD_BEEF});
        cycle();
        set_req(REQ_ALU, 1'b0, 5'd0, 32'h0);
        check("single_wr_en", {63'd0, wb.rf_wr_en}, 64'd1);
        cycle();
        check("x5_readback", {32'd0, rf_model[5]}, 64'hDEAD_BEEF);

        // rd=0 write: handshake only, pointer 1 -> 2
        set_req(REQ_LSU, 1'b1, 5'd0, 32'h0000_1234);
        #1;
        check("rd0_ready", {61'd0, wb.req_ready}, 64'b010);
        cycle();
        set_req(REQ_LSU, 1'b0, 5'd0, 32'h0);
        check("rd0_wr_en", {63'd0, wb.rf_wr_en}, 64'd0);
        cycle();
        check("x0_unchanged", {32'd0, rf_model[0]}, 64'd0);

        // All valid from pointer 2: strict rotation 2,0,1,2,0,1,2
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 5'(i + 1), 32'hA000_0000 | 32'(i));
        for (int c = 0; c < 7; c++) begin
            int g;
            g = (2 + c) % N;
            #1;
            check($sformatf("rr_ready_%0d", c), {61'd0, wb.req_ready}, 64'(1 << g));
            exp_q.push_back('{rd: 5'(g + 1), data: 32'hA000_0000 | 32'(g)});
            cycle();
        end
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 5'd0, 32'h0);
        cycle();

        // Scoreboard set, query, commit-clear
        sb_set_valid = 1'b1; sb_set_rd = 5'd7;
        cycle();
        sb_set_valid = 1'b0;
        q_rs1 = 5'd7; q_rs2 = 5'd8;
        #1;
        check("busy7_set", {63'd0, busy[7]}, 64'd1);
        check("q_rs1_busy", {63'd0, q_rs1_busy}, 64'd1);
        check("q_rs2_idle", {63'd0, q_rs2_busy}, 64'd0);
        set_req(REQ_LSU, 1'b1, 5'd7, 32'h0000_0077);
        exp_q.push_back('{rd: 5'd7, data: 32'h0000_0077});
        cycle();
        set_req(REQ_LSU, 1'b0, 5'd0, 32'h0);
        check("busy7_during_commit", {63'd0, busy[7]}, 64'd1);
        cycle();
        check("busy7_cleared", {63'd0, busy[7]}, 64'd0);

        // Set and commit of x7 in the same cycle: set wins
        set_req(REQ_CSR, 1'b1, 5'd7, 32'h0000_7777);
        exp_q.push_back('{rd: 5'd7, data: 32'h0000_7777});
        cycle();
        set_req(REQ_CSR, 1'b0, 5'd0, 32'h0);
        sb_set_valid = 1'b1; sb_set_rd = 5'd7;
        cycle();
        sb_set_valid = 1'b0;
        check("busy7_set_wins", {63'd0, busy[7]}, 64'd1);

        // Flush
        sb_flush = 1'b1;
        cycle();
        sb_flush = 1'b0;
        check("flush_all", {32'd0, busy}, 64'd0);
        sb_set_valid = 1'b1; sb_set_rd = 5'd3;
        cycle();
        sb_set_rd = 5'd9;
        cycle();
        sb_set_valid = 1'b0;
        check("busy_3_9", {32'd0, busy}, 64'h0000_0208);
        sb_flush = 1'b1; sb_set_valid = 1'b1; sb_set_rd = 5'd4;
        cycle();
        sb_flush = 1'b0; sb_set_rd = 5'd0;
        check("flush_set4", {32'd0, busy}, 64'h0000_0010);
        cycle();
        sb_set_valid = 1'b0;
        check("set_x0_ignored", {32'd0, busy}, 64'h0000_0010);

        // Reset mid-stream while a write is on the port
        set_req(REQ_ALU, 1'b1, 5'd9, 32'h0000_0099);
        cycle();
        set_req(REQ_ALU, 1'b0, 5'd0, 32'h0);
        check("pre_reset_wr_en", {63'd0, wb.rf_wr_en}, 64'd1);
        #1 reset_n = 1'b0;
        #1;
        check("async_reset_wr_en", {63'd0, wb.rf_wr_en}, 64'd0);
        check("async_reset_busy", {32'd0, busy}, 64'd0);
        @(negedge clock);
        #2 reset_n = 1'b1;
        cycle();
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 5'(i + 1), 32'hB000_0000 | 32'(i));
        #1;
        check("reset_ptr_ready", {61'd0, wb.req_ready}, 64'b001);
        exp_q.push_back('{rd: 5'd1, data: 32'hB000_0000});
        cycle();
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 5'd0, 32'h0);
        repeat (3) cycle();
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_regfile_wb_arbiter
